// File: rtl/dct_tp_pkg.sv
// rtl/dct_tp_pkg.sv - shared types and constants for the ping-pong DCT transpose buffer
package dct_tp_pkg;

  localparam int NUM_BANKS = 2;

  typedef logic bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// rtl/dct_tp_bank.sv - NxN sample register array, row-write port and column-read mux
module dct_tp_bank
  import dct_tp_pkg::*;
#(
  parameter int SIZE = 10,
  parameter int N    = 8,
  parameter int CW   = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [CW-1:0]          wrow,
  input  logic [N-1:0][SIZE-1:0] wdata,
  input  logic [CW-1:0]          rcol,
  output logic [N-1:0][SIZE-1:0] rdata
);

  // mem[row][col]
  logic [N-1:0][N-1:0][SIZE-1:0] mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (we) begin
      mem[wrow] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      rdata[i] = mem[i][rcol];
    end
  end

endmodule

// File: rtl/dct_transpose_pingpong.sv
// rtl/dct_transpose_pingpong.sv - double-buffered NxN transpose between row and column DCT stages
// Optional synchronous partial-block flush input is built when DCT_TP_FLUSH_EN is defined.
module dct_transpose_pingpong
  import dct_tp_pkg::*;
#(
  parameter int  SIZE = 10,
  parameter int  N    = 8,
  localparam int CW   = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0][SIZE-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0][SIZE-1:0] out_data,
  output logic [CW-1:0]          out_col,
  output logic                   out_last,
  output logic [NUM_BANKS-1:0]   bank_full
`ifdef DCT_TP_FLUSH_EN
  ,
  input  logic                   flush
`endif
);

  typedef logic [CW-1:0] rc_cnt_t;
  localparam rc_cnt_t LAST_IDX = rc_cnt_t'(N - 1);

  bank_sel_t wbank;
  bank_sel_t rbank;
  rc_cnt_t   wrow;
  rc_cnt_t   rcol;
  logic      flush_req;
  logic      wr_fire;
  logic      rd_fire;

  logic [NUM_BANKS-1:0]                   bank_we;
  logic [NUM_BANKS-1:0][N-1:0][SIZE-1:0]  bank_rdata;

`ifdef DCT_TP_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready  = !bank_full[wbank];
  assign out_valid = bank_full[rbank];
  assign out_col   = rcol;
  assign out_last  = out_valid && (rcol == LAST_IDX);
  assign out_data  = bank_rdata[rbank];

  // A flushed cycle never writes, so the discarded row cannot land in storage.
  assign wr_fire = in_valid && in_ready && !flush_req;
  assign rd_fire = out_valid && out_ready;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (wbank == 1'(b));

    dct_tp_bank #(
      .SIZE (SIZE),
      .N    (N),
      .CW   (CW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[b]),
      .wrow  (wrow),
      .wdata (in_data),
      .rcol  (rcol),
      .rdata (bank_rdata[b])
    );
  end

  // Write only targets an empty bank and read only a full one, so the set and
  // clear of bank_full always hit different bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wrow      <= '0;
      rcol      <= '0;
    end else begin
      if (flush_req) begin
        wrow <= '0;
      end else if (wr_fire) begin
        if (wrow == LAST_IDX) begin
          bank_full[wbank] <= 1'b1;
          wbank            <= other_bank(wbank);
          wrow             <= '0;
        end else begin
          wrow <= wrow + rc_cnt_t'(1);
        end
      end

      if (rd_fire) begin
        if (rcol == LAST_IDX) begin
          bank_full[rbank] <= 1'b0;
          rbank            <= other_bank(rbank);
          rcol             <= '0;
        end else begin
          rcol <= rcol + rc_cnt_t'(1);
        end
      end
    end
  end

endmodule
